uart_receiver: RTL and testbench

Asynchronous 8N1 serial receiver: the receive-side counterpart to the UART transmitter on the same line settings. It oversamples the `rx` pin at 16x baud and validates the start bit at mid-bit. Data bits are shifted in LSB first and the stop bit is checked. Each good byte goes out on a valid/ready port toward the system bus interface, with one-cycle framing-error and overrun flags.

---
 rtl/uart_receiver.sv | 152 +++++++++++++++
 tb/tb_uart_receiver.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 16x oversampling, mid-bit decisions, valid/ready output.
// Define UART_RX_MAJORITY_VOTE_EN for a 2-of-3 vote at phases 6/7/8.
module uart_receiver #(
    parameter int CLK_HZ    = 100000000,
    parameter int BAUD_RATE = 460800
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] read_data,
    output logic       read_valid,
    input  logic       read_ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int OVS_DIV = CLK_HZ / (BAUD_RATE * 16);
    localparam int DIV_W   = $clog2(OVS_DIV + 1);

    if (OVS_DIV < 2) begin : g_bad_div
        $error("uart_receiver: OVS_DIV must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nx;
    logic             rx_meta, rx_s, rx_prev;
    logic [DIV_W-1:0] div_cnt, div_nx;
    logic [3:0]       phase, phase_nx;
    logic [2:0]       bit_idx, bit_idx_nx;
    logic [7:0]       shift, shift_nx;
    logic [7:0]       data_nx;
    logic             valid_nx, ferr_nx, ovr_nx;
    logic             fall, tick, decide, sample;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign fall   = rx_prev & ~rx_s;
    assign tick   = (state != IDLE) && (div_cnt == DIV_W'(OVS_DIV - 1));
    assign decide = tick && (phase == 4'd8);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic vote6, vote7;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vote6 <= 1'b1;
            vote7 <= 1'b1;
        end else if (tick) begin
            if (phase == 4'd6) vote6 <= rx_s;
            if (phase == 4'd7) vote7 <= rx_s;
        end
    end

    assign sample = (vote6 & vote7) | (vote6 & rx_s) | (vote7 & rx_s);
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            div_cnt       <= '0;
            phase         <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            read_data     <= '0;
            read_valid    <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state         <= state_nx;
            div_cnt       <= div_nx;
            phase         <= phase_nx;
            bit_idx       <= bit_idx_nx;
            shift         <= shift_nx;
            read_data     <= data_nx;
            read_valid    <= valid_nx;
            framing_error <= ferr_nx;
            overrun       <= ovr_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        div_nx     = div_cnt;
        phase_nx   = phase;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        data_nx    = read_data;
        valid_nx   = read_valid & ~read_ready;
        ferr_nx    = 1'b0;
        ovr_nx     = 1'b0;

        if (state != IDLE) begin
            div_nx = tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) phase_nx = phase + 4'd1;
        end

        unique case (state)
            IDLE: begin
                div_nx     = '0;
                phase_nx   = '0;
                bit_idx_nx = '0;
                if (fall) state_nx = START;
            end
            START: begin
                if (decide) begin
                    if (sample) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx   = DATA;
                        bit_idx_nx = '0;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    // LSB arrives first, so shifting right lands it in bit 0.
                    shift_nx = {sample, shift[7:1]};
                    if (bit_idx == 3'd7) state_nx = STOP;
                    else bit_idx_nx = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (decide) begin
                    state_nx = IDLE;
                    if (!sample) begin
                        ferr_nx = 1'b1;
                    end else if (!read_valid || read_ready) begin
                        data_nx  = shift;
                        valid_nx = 1'b1;
                    end else begin
                        ovr_nx = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized bench for uart_receiver against a frame-level output model.
// Glitch-vote scenario runs only with UART_RX_MAJORITY_VOTE_EN defined.
module tb_uart_receiver;

    localparam int CLK_HZ = 7372800;
    localparam int BAUD   = 115200;
    localparam int OVS    = CLK_HZ / (BAUD * 16);
    localparam int BIT    = OVS * 16;
    // sync (2) + edge register (1) + ticks up to and including stop mid-bit
    localparam int LAT    = 3 + (9 * 16 + 8 + 1) * OVS;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       read_ready = 1'b0;
    logic [7:0] read_data;
    logic       read_valid;
    logic       framing_error;
    logic       overrun;

    always #5 clk = ~clk;

    uart_receiver #(
        .CLK_HZ   (CLK_HZ),
        .BAUD_RATE(BAUD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .read_ready   (read_ready),
        .framing_error(framing_error),
        .overrun      (overrun)
    );

    typedef struct {
        int         due;
        logic       good;
        logic [7:0] data;
    } ev_t;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    ev_t        evq[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_ferr = 1'b0;
    logic       m_ovr = 1'b0;
    bit         mask = 1'b0;
    bit         rnd_rdy = 1'b0;
    logic [7:0] beats[$];
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Frame-level model: each sent frame resolves LAT cycles after its edge.
    initial begin
        ev_t ev;
        forever begin
            @(posedge clk);
            cyc++;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            if (!reset_n) begin
                m_valid = 1'b0;
                m_data  = 8'h00;
                evq.delete();
            end else begin
                if (m_valid && read_ready) m_valid = 1'b0;
                if (evq.size() > 0 && evq[0].due == cyc) begin
                    ev = evq.pop_front();
                    if (!ev.good) m_ferr = 1'b1;
                    else if (!m_valid) begin
                        m_valid = 1'b1;
                        m_data  = ev.data;
                    end else m_ovr = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (framing_error === 1'b1) ferr_cnt++;
            if (overrun === 1'b1) ovr_cnt++;
            if (read_valid === 1'b1 && read_ready) beats.push_back(read_data);
            if (!mask) begin
                chk("valid", {31'd0, read_valid}, {31'd0, m_valid});
                if (m_valid) chk("data", {24'd0, read_data}, {24'd0, m_data});
                chk("ferr", {31'd0, framing_error}, {31'd0, m_ferr});
                chk("ovr", {31'd0, overrun}, {31'd0, m_ovr});
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) read_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic stopb,
                        input bit glitch);
        logic [9:0] bits;
        bits = {stopb, d, 1'b0};
        @(posedge clk);
        #1;
        evq.push_back('{due: cyc + LAT, good: stopb, data: d});
        for (int b = 0; b < 10; b++) begin
            rx = bits[b];
            for (int c = 0; c < BIT; c++) begin
                if (glitch && b == 1 && c == 36) rx = 1'b0;
                if (glitch && b == 1 && c == 40) rx = bits[b];
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout cyc=%0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic       s;

        idle(3);
        @(negedge clk);
        chk("rst_valid", {31'd0, read_valid}, 32'd0);
        chk("rst_data", {24'd0, read_data}, 32'd0);
        chk("rst_ferr", {31'd0, framing_error}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(5);

        // single byte, held
        send(8'hA5, 1'b1, 1'b0);
        idle(1000 - 10 * BIT);
        chk("a5_valid", {31'd0, read_valid}, 32'd1);
        chk("a5_data", {24'd0, read_data}, 32'hA5);
        read_ready = 1'b1;
        idle(1);
        read_ready = 1'b0;
        @(negedge clk);
        chk("a5_cleared", {31'd0, read_valid}, 32'd0);

        // back-to-back
        beats.delete();
        ferr_cnt = 0;
        ovr_cnt  = 0;
        read_ready = 1'b1;
        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        idle(200);
        chk("b2b_count", beats.size(), 32'd2);
        if (beats.size() == 2) begin
            chk("b2b_first", {24'd0, beats[0]}, 32'h00);
            chk("b2b_second", {24'd0, beats[1]}, 32'hFF);
        end
        chk("b2b_flags", ferr_cnt + ovr_cnt, 32'd0);

        // short low glitch, then a real frame
        beats.delete();
        @(posedge clk);
        #1;
        rx = 1'b0;
        idle(20);
        rx = 1'b1;
        idle(700);
        chk("glitch_none", beats.size(), 32'd0);
        send(8'h3C, 1'b1, 1'b0);
        idle(100);
        chk("glitch_rearm", beats.size(), 32'd1);
        if (beats.size() == 1) chk("glitch_3c", {24'd0, beats[0]}, 32'h3C);
`ifdef UART_RX_MAJORITY_VOTE_EN
        beats.delete();
        send(8'hFF, 1'b1, 1'b1);
        idle(100);
        chk("vote_count", beats.size(), 32'd1);
        if (beats.size() == 1) chk("vote_ff", {24'd0, beats[0]}, 32'hFF);
`endif

        // framing error then stuck-low line
        read_ready = 1'b0;
        ferr_cnt = 0;
        send(8'h3C, 1'b0, 1'b0);
        idle(20 * BIT);
        rx = 1'b1;
        idle(BIT);
        send(8'h5A, 1'b1, 1'b0);
        idle(700);
        chk("fe_count", ferr_cnt, 32'd1);
        chk("fe_valid", {31'd0, read_valid}, 32'd1);
        chk("fe_5a", {24'd0, read_data}, 32'h5A);

        // overrun
        read_ready = 1'b1;
        idle(2);
        read_ready = 1'b0;
        ovr_cnt = 0;
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        idle(700);
        chk("ovr_count", ovr_cnt, 32'd1);
        chk("ovr_valid", {31'd0, read_valid}, 32'd1);
        chk("ovr_data", {24'd0, read_data}, 32'h11);

        // reset in data bit 3; the abandoned tail may frame garbage
        read_ready = 1'b1;
        fork
            send(8'h77, 1'b1, 1'b0);
            begin
                idle(4 * BIT + 32);
                reset_n = 1'b0;
                idle(1);
                reset_n = 1'b1;
                mask = 1'b1;
                @(negedge clk);
                chk("mid_rst_valid", {31'd0, read_valid}, 32'd0);
                chk("mid_rst_data", {24'd0, read_data}, 32'd0);
                chk("mid_rst_flags", {30'd0, framing_error, overrun}, 32'd0);
            end
        join
        idle(1500);
        mask = 1'b0;
        beats.delete();
        send(8'hC3, 1'b1, 1'b0);
        idle(100);
        chk("c3_count", beats.size(), 32'd1);
        if (beats.size() == 1) chk("c3_data", {24'd0, beats[0]}, 32'hC3);

        // random frames, random stop bits and consumer stalls
        rnd_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 7) != 0);
            send(d, s, 1'b0);
            if (!s) begin
                rx = 1'b1;
                idle(BIT);
            end
            idle($urandom_range(0, 100));
        end
        rnd_rdy = 1'b0;
        read_ready = 1'b1;
        idle(800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
